dcache_nway: RTL
================

Name: dcache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache. Successor to the fixed single-configuration cache.
- Sits between the pipeline memory stage and the line-based data memory, using the existing mem_req/mem_ready line handshake.
- Generalised in associativity, set count and line size. Adds dirty-victim writeback, a per-set round-robin replacement pointer and byte-mode stores.

Parameters:
DATA_WIDTH, 32, CPU word width in bits
WAYS, 2, associativity (power of two, 1..8)
SETS, 4, sets per way (power of two, >=2)
LINE_WORDS, 4, words per line (power of two); line width = LINE_WORDS*DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  1  CPU access valid this cycle (load or store)
we  in  1  1 = store, 0 = load
addr_mode  in  1  0 = word access, 1 = byte access
addr  in  DATA_WIDTH  byte address
wdata  in  DATA_WIDTH  store data (byte mode uses wdata[7:0])
rdata  out  DATA_WIDTH  load data; byte mode zero-extended
stall  out  1  1 = access not complete, pipeline must hold
mem_req  out  1  line transfer request, held until mem_ready
mem_we  out  1  1 = line writeback, 0 = line refill
mem_addr  out  DATA_WIDTH  line-aligned address
mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line
mem_rdata  in  LINE_WORDS*DATA_WIDTH  refill line
mem_ready  in  1  one-cycle pulse: transfer done, mem_rdata valid for refill

Behaviour:
- Address split: byte offset = low log2(LINE_WORDS*DATA_WIDTH/8) bits; index = next log2(SETS) bits; tag = remainder. Word accesses assume word alignment; misaligned word access is undefined.
- Reset (rst low, asynchronous):
  - All valid/dirty bits and replacement pointers cleared; FSM to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
  - stall follows req combinationally, per the IDLE rule.
  - Reset mid-transfer aborts the transfer; mem_req drops asynchronously. Tags and data arrays need not be cleared.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - Hit (any way valid with matching tag) with req=1: stall=0 in the same cycle.
  - Load hit: rdata is combinational from the hit way.
  - Store hit: the word, or the byte selected by addr[1:0], is updated at the clock edge; line dirty bit set.
  - Miss with req=1: stall=1 combinationally. Victim = lowest-numbered invalid way, else the set's round-robin pointer.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
  - req=0: no state change; rdata holds its last value and is don't-care.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line; stall=1.
  - On mem_ready, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {addr tag, index, 0}; stall=1.
  - On mem_ready: capture mem_rdata into the victim way; set valid, clear dirty, write tag; advance the set's pointer (mod WAYS); go to IDLE.
- After refill: the next IDLE cycle re-evaluates as a hit and completes the access with stall=0. A store merges then, setting dirty. Miss latency = memory latency + 1 cycle.
- mem_req deasserts in the cycle after mem_ready. Back-to-back WRITEBACK then REFILL re-asserts mem_req without a gap.
- CPU inputs must be held stable while stall=1. The cache latches nothing from the CPU side during a miss; addr is re-sampled each cycle.
- WAYS=1 degenerates to direct-mapped with no pointer.
- Two ways hitting simultaneously cannot occur by construction (refill only on miss); the lowest way wins if it does.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined: adds outputs hit_cnt and miss_cnt, each 32 bits, both reset to 0.
  - hit_cnt increments on each IDLE cycle with req=1 and hit, excluding the completing cycle of a miss.
  - miss_cnt increments on each IDLE-to-WRITEBACK/REFILL transition.
  - Both saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent, with no other behavioural difference.

Test Plan:
- Cold load 0x100, memory returns line {0xD,0xC,0xB,0xA} after 3 cycles -> one refill request (mem_we=0, mem_addr=0x100); stall high 4 cycles; rdata=0xA; repeat load of 0x104 -> stall=0, rdata=0xB.
- Store word 0xDEADBEEF to 0x108 (hit), then fill 0x140 and 0x180 (same index 0, WAYS=2) -> writeback with mem_addr=0x100, mem_we=1, word 2 = 0xDEADBEEF, followed by a refill of 0x180.
- Byte store 0x5A to 0x101 on a line holding 0x11223344 at 0x100 -> word load of 0x100 returns 0x11225A44; byte load of 0x101 returns 0x0000005A.
- Miss on a clean victim -> no writeback phase; mem_req high only in REFILL.
- rst low during WRITEBACK with mem_req=1 -> mem_req=0 immediately; load of 0x100 after release misses (valid cleared).
- With DCACHE_PERF_CNT_EN: 1 miss then 3 hits -> miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/dcache_nway.sv
// -----------------------------------------------------------------------------
// dcache_nway
// N-way set-associative, write-back, write-allocate data cache placed between
// the pipeline memory stage and a line-based data memory.
//
// Optional build macro: DCACHE_PERF_CNT_EN adds saturating 32-bit hit_cnt and
// miss_cnt outputs. Without it the cache behaves identically, minus the ports.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req        CPU access valid (load or store)
//   we         1 = store, 0 = load
//   addr_mode  0 = word access, 1 = byte access
//   addr       byte address (re-sampled every cycle, held stable while stalled)
//   wdata      store data; byte mode uses wdata[7:0]
//   rdata      load data; byte loads are zero-extended
//   stall      access not complete this cycle
//   mem_req    line transfer request, held until mem_ready
//   mem_we     1 = victim writeback, 0 = refill
//   mem_addr   line-aligned transfer address
//   mem_wdata  victim line for writeback
//   mem_rdata  refill line, valid with mem_ready
//   mem_ready  one-cycle pulse: transfer finished
//   hit_cnt    (DCACHE_PERF_CNT_EN) completed hit accesses, saturating
//   miss_cnt   (DCACHE_PERF_CNT_EN) misses started, saturating
// -----------------------------------------------------------------------------
module dcache_nway #(
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req,
  input  logic                             we,
  input  logic                             addr_mode,
  input  logic [DATA_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             stall,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                             mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt
`endif
);

  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BOFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = DATA_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  // Storage: tags and line data are never reset; valid/dirty/pointers are.
  logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
  logic [LINE_W-1:0] data_arr  [WAYS][SETS];
  logic              valid_arr [WAYS][SETS];
  logic              dirty_arr [WAYS][SETS];
  logic [WAY_W-1:0]  rr_ptr    [SETS];

  logic [1:0]            state;
  logic [WAY_W-1:0]      victim_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [OFF_W-1:0]      off;
  logic [WSEL_W-1:0]     word_sel;
  logic [BOFF_W-1:0]     byte_sel;

  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim;
  logic [LINE_W-1:0]     line_hit;
  logic [DATA_WIDTH-1:0] word_hit;
  logic [7:0]            byte_hit;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  access_hit;
  logic                  access_miss;

  function automatic logic [WAY_W-1:0] next_ptr(input logic [WAY_W-1:0] p);
    // Power-of-two WAYS wraps naturally; a single way keeps the pointer at 0.
    if (WAYS == 1) return '0;
    return p + WAY_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign idx      = addr[OFF_W +: IDX_W];
  assign tag      = addr[DATA_WIDTH-1 -: TAG_W];
  assign off      = addr[OFF_W-1:0];
  assign word_sel = WSEL_W'(off >> BOFF_W);
  assign byte_sel = addr[BOFF_W-1:0];

  // ---- Lookup stage: tag compare, victim choice, read mux ----
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_ptr[idx];
    // Descending scan so the lowest-numbered way wins both searches.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[w][idx] && (tag_arr[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_arr[w][idx]) begin
        victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    line_hit = data_arr[hit_way][idx];
    word_hit = line_hit[word_sel*DATA_WIDTH +: DATA_WIDTH];
    byte_hit = word_hit[byte_sel*8 +: 8];
    load_val = addr_mode ? DATA_WIDTH'(byte_hit) : word_hit;
  end

  assign access_hit  = (state == S_IDLE) && req && hit;
  assign access_miss = (state == S_IDLE) && req && !hit;

  // rdata is live on a load hit and otherwise replays the last load result.
  assign rdata = (access_hit && !we) ? load_val : rdata_q;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = req && !hit;
    case (state)
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_arr[victim_q][idx], idx, {OFF_W{1'b0}}};
        mem_wdata = data_arr[victim_q][idx];
        stall     = 1'b1;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, {OFF_W{1'b0}}};
        stall    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- Control state: FSM, valid/dirty, replacement pointers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      victim_q <= '0;
      rdata_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (access_miss) begin
            victim_q <= victim;
            state    <= (valid_arr[victim][idx] && dirty_arr[victim][idx]) ? S_WB : S_REFILL;
          end else if (access_hit) begin
            if (we) begin
              dirty_arr[hit_way][idx] <= 1'b1;
            end else begin
              rdata_q <= load_val;
            end
          end
        end
        S_WB: begin
          if (mem_ready) state <= S_REFILL;
        end
        S_REFILL: begin
          if (mem_ready) begin
            valid_arr[victim_q][idx] <= 1'b1;
            dirty_arr[victim_q][idx] <= 1'b0;
            rr_ptr[idx]              <= next_ptr(rr_ptr[idx]);
            state                    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- Array write stage: refill capture and store merge ----
  always_ff @(posedge clk) begin
    if ((state == S_REFILL) && mem_ready) begin
      data_arr[victim_q][idx] <= mem_rdata;
      tag_arr[victim_q][idx]  <= tag;
    end else if (access_hit && we) begin
      if (addr_mode) begin
        data_arr[hit_way][idx][word_sel*DATA_WIDTH + byte_sel*8 +: 8] <= wdata[7:0];
      end else begin
        data_arr[hit_way][idx][word_sel*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // ---- Performance counters ----
  // The cycle right after a refill completes the missed access; it is not a hit.
  logic refill_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= (state == S_REFILL) && mem_ready;
      if (access_hit && !refill_done) hit_cnt <= sat_inc(hit_cnt);
      if (access_miss) miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule
